// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcodes, state encodings and datapath select codes for control_multi
package mips_ctrl_pkg;

  localparam logic [5:0] R_FORMAT = 6'd0;
  localparam logic [5:0] LW       = 6'd35;
  localparam logic [5:0] SW       = 6'd43;
  localparam logic [5:0] BEQ      = 6'd4;
  localparam logic [5:0] J        = 6'd2;
  localparam logic [5:0] ADDI     = 6'd8;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BEQ     = 4'd8,
    S_JUMP    = 4'd9,
    S_ADDI_EX = 4'd10,
    S_ADDI_WB = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/control_multi_retire_cnt.sv
// rtl/control_multi_retire_cnt.sv - wrapping retired-instruction counter with async active-low clear
module control_multi_retire_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_multi.sv
// rtl/control_multi.sv - multicycle MIPS control FSM with memory wait states, sticky illegal-opcode flag
module control_multi
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ALUSrcB,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [3:0]       state,
  output logic             retire,
  output logic             error,
  output logic [CNT_W-1:0] instr_count
);

  state_t r_state;
  state_t w_next;
  logic   r_error;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:   if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          LW, SW:   w_next = S_MEMADR;
          R_FORMAT: w_next = S_EXEC;
          BEQ:      w_next = S_BEQ;
          J:        w_next = S_JUMP;
          ADDI:     w_next = S_ADDI_EX;
          default:  w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (opcode == LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWR:   if (mem_ready) w_next = S_FETCH;
      S_EXEC:    w_next = S_RWB;
      S_RWB:     w_next = S_FETCH;
      S_BEQ:     w_next = S_FETCH;
      S_JUMP:    w_next = S_FETCH;
      S_ADDI_EX: w_next = S_ADDI_WB;
      S_ADDI_WB: w_next = S_FETCH;
      S_ILLEGAL: w_next = S_ILLEGAL;
      default:   w_next = S_ILLEGAL;
    endcase
  end

  // FETCH loads PC/IR only when the read completes, and never while reset is held.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_ADD;
    ALUSrcB     = SRCB_B;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    retire      = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready & reset_n;
        PCWrite = mem_ready & reset_n;
      end
      S_DECODE:  ALUSrcB = SRCB_IMM_SH;
      S_MEMADR, S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        retire   = mem_ready;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_FUNCT;
      end
      S_RWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALUOP_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        retire      = 1'b1;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = PCSRC_JUMP;
        retire   = 1'b1;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                r_error <= 1'b0;
    else if (w_next == S_ILLEGAL) r_error <= 1'b1;
  end

  control_multi_retire_cnt #(.CNT_W(CNT_W)) u_retire_cnt (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_en    (retire),
    .o_count (instr_count)
  );

  assign state = r_state;
  assign error = r_error;

endmodule

// File: tb/tb_control_multi.sv
// tb/tb_control_multi.sv - table-driven and directed checks for control_multi
module tb_control_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst;
  logic [3:0] state;
  logic       retire, error;
  logic [3:0] instr_count;

  control_multi #(.CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
    .ALUOp(ALUOp), .ALUSrcB(ALUSrcB), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .state(state), .retire(retire), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // PW PWC IorD MR MW M2R IRW | PCSource | ALUOp | ALUSrcB | ALUSrcA RW RD
  logic [15:0] w_ctrl;
  assign w_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst};

  localparam logic [15:0] K_FETCH1 = 16'b1001001_00_00_01_000;
  localparam logic [15:0] K_FETCH0 = 16'b0001000_00_00_01_000;
  localparam logic [15:0] K_DEC    = 16'b0000000_00_00_11_000;
  localparam logic [15:0] K_MADR   = 16'b0000000_00_00_10_100;
  localparam logic [15:0] K_MRD    = 16'b0011000_00_00_00_000;
  localparam logic [15:0] K_MWB    = 16'b0000010_00_00_00_010;
  localparam logic [15:0] K_MWR    = 16'b0010100_00_00_00_000;
  localparam logic [15:0] K_EXEC   = 16'b0000000_00_10_00_100;
  localparam logic [15:0] K_RWB    = 16'b0000000_00_00_00_011;
  localparam logic [15:0] K_BEQ    = 16'b0100000_01_01_00_100;
  localparam logic [15:0] K_JMP    = 16'b1000000_10_00_00_000;
  localparam logic [15:0] K_AWB    = 16'b0000000_00_00_00_010;
  localparam logic [15:0] K_NONE   = 16'b0000000_00_00_00_000;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] ctrl;
    logic        ret;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(input logic [5:0] op, input logic mr, input logic [3:0] st,
                              input logic [15:0] ctrl, input logic ret, input logic [3:0] cnt);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st; v.ctrl = ctrl; v.ret = ret; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cycle(input logic [5:0] op, input logic mr);
    opcode    = op;
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // R-format, no stalls
    vecs.push_back(mk(6'd0,  1, 4'd0,  K_FETCH1, 0, 4'd0));
    vecs.push_back(mk(6'd0,  1, 4'd1,  K_DEC,    0, 4'd0));
    vecs.push_back(mk(6'd0,  1, 4'd6,  K_EXEC,   0, 4'd0));
    vecs.push_back(mk(6'd0,  1, 4'd7,  K_RWB,    1, 4'd0));
    // LW with two wait states in MEMRD
    vecs.push_back(mk(6'd35, 1, 4'd0,  K_FETCH1, 0, 4'd1));
    vecs.push_back(mk(6'd35, 1, 4'd1,  K_DEC,    0, 4'd1));
    vecs.push_back(mk(6'd35, 1, 4'd2,  K_MADR,   0, 4'd1));
    vecs.push_back(mk(6'd35, 0, 4'd3,  K_MRD,    0, 4'd1));
    vecs.push_back(mk(6'd35, 0, 4'd3,  K_MRD,    0, 4'd1));
    vecs.push_back(mk(6'd35, 1, 4'd3,  K_MRD,    0, 4'd1));
    vecs.push_back(mk(6'd35, 1, 4'd4,  K_MWB,    1, 4'd1));
    // SW, no stalls
    vecs.push_back(mk(6'd43, 1, 4'd0,  K_FETCH1, 0, 4'd2));
    vecs.push_back(mk(6'd43, 1, 4'd1,  K_DEC,    0, 4'd2));
    vecs.push_back(mk(6'd43, 1, 4'd2,  K_MADR,   0, 4'd2));
    vecs.push_back(mk(6'd43, 1, 4'd5,  K_MWR,    1, 4'd2));
    // BEQ with one FETCH wait state
    vecs.push_back(mk(6'd4,  0, 4'd0,  K_FETCH0, 0, 4'd3));
    vecs.push_back(mk(6'd4,  1, 4'd0,  K_FETCH1, 0, 4'd3));
    vecs.push_back(mk(6'd4,  1, 4'd1,  K_DEC,    0, 4'd3));
    vecs.push_back(mk(6'd4,  1, 4'd8,  K_BEQ,    1, 4'd3));
    // J
    vecs.push_back(mk(6'd2,  1, 4'd0,  K_FETCH1, 0, 4'd4));
    vecs.push_back(mk(6'd2,  1, 4'd1,  K_DEC,    0, 4'd4));
    vecs.push_back(mk(6'd2,  1, 4'd9,  K_JMP,    1, 4'd4));
    // ADDI, mem_ready low outside memory states is ignored
    vecs.push_back(mk(6'd8,  1, 4'd0,  K_FETCH1, 0, 4'd5));
    vecs.push_back(mk(6'd8,  0, 4'd1,  K_DEC,    0, 4'd5));
    vecs.push_back(mk(6'd8,  0, 4'd10, K_MADR,   0, 4'd5));
    vecs.push_back(mk(6'd8,  0, 4'd11, K_AWB,    1, 4'd5));
    // SW with one MEMWR wait state
    vecs.push_back(mk(6'd43, 1, 4'd0,  K_FETCH1, 0, 4'd6));
    vecs.push_back(mk(6'd43, 1, 4'd1,  K_DEC,    0, 4'd6));
    vecs.push_back(mk(6'd43, 1, 4'd2,  K_MADR,   0, 4'd6));
    vecs.push_back(mk(6'd43, 0, 4'd5,  K_MWR,    0, 4'd6));
    vecs.push_back(mk(6'd43, 1, 4'd5,  K_MWR,    1, 4'd6));
    vecs.push_back(mk(6'd0,  0, 4'd0,  K_FETCH0, 0, 4'd7));

    reset_n   = 1'b0;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ctrl", 32'(w_ctrl), 32'(K_FETCH0));
    mem_ready = 1'b1;
    #1;
    chk("rst_ctrl_mr1", 32'(w_ctrl), 32'(K_FETCH0));
    mem_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      opcode    = vecs[i].op;
      mem_ready = vecs[i].mr;
      #1;
      chk($sformatf("v%0d_state", i), 32'(state), 32'(vecs[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(w_ctrl), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_retire", i), 32'(retire), 32'(vecs[i].ret));
      chk($sformatf("v%0d_count", i), 32'(instr_count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_error", i), 32'(error), 32'd0);
      @(posedge clk);
      #1;
    end

    // Illegal opcode: sticky until reset
    cycle(6'd63, 1'b1);
    cycle(6'd63, 1'b1);
    chk("ill_state", 32'(state), 32'd12);
    chk("ill_error", 32'(error), 32'd1);
    chk("ill_ctrl", 32'(w_ctrl), 32'(K_NONE));
    chk("ill_retire", 32'(retire), 32'd0);
    for (int k = 0; k < 10; k++) begin
      cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      chk($sformatf("ill_hold%0d_state", k), 32'(state), 32'd12);
      chk($sformatf("ill_hold%0d_error", k), 32'(error), 32'd1);
      chk($sformatf("ill_hold%0d_ctrl", k), 32'(w_ctrl), 32'(K_NONE));
    end
    chk("ill_count", 32'(instr_count), 32'd7);
    mem_ready = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk("ill_rst_state", 32'(state), 32'd0);
    chk("ill_rst_error", 32'(error), 32'd0);
    chk("ill_rst_count", 32'(instr_count), 32'd0);
    chk("ill_rst_ctrl", 32'(w_ctrl), 32'(K_FETCH0));
    mem_ready = 1'b0;
    reset_n   = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of a stalled store
    repeat (3) cycle(6'd2, 1'b1);
    chk("mw_pre_count", 32'(instr_count), 32'd1);
    repeat (3) cycle(6'd43, 1'b1);
    mem_ready = 1'b0;
    #1;
    chk("mw_state", 32'(state), 32'd5);
    chk("mw_memwrite", 32'(MemWrite), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mw_rst_memwrite", 32'(MemWrite), 32'd0);
    chk("mw_rst_state", 32'(state), 32'd0);
    chk("mw_rst_count", 32'(instr_count), 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mw_after_count", 32'(instr_count), 32'd0);

    // Counter wrap at 4 bits
    for (int n = 0; n < 15; n++) repeat (3) cycle(6'd2, 1'b1);
    chk("wrap_15", 32'(instr_count), 32'd15);
    repeat (3) cycle(6'd2, 1'b1);
    chk("wrap_0", 32'(instr_count), 32'd0);
    chk("wrap_state", 32'(state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
